// File: rtl/uart_rx_os16.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_os16
// Purpose  : UART receiver with 16x oversampling and a 3-sample majority vote.
//            Checks the start, data, parity and stop bits. Delivers each word
//            with a one-cycle strobe and a held error flag.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_os16 #(
  parameter int    CLK_FREQ   = 50_000_000,
  parameter int    BAUD_RATE  = 115200,
  parameter string PARITY     = "EVEN",
  parameter int    DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_done,
  output logic                  rx_error,
  output logic                  rx_busy
);

  localparam int c_OS_DIV  = (CLK_FREQ + 8 * BAUD_RATE) / (16 * BAUD_RATE);
  localparam int c_DIV_W   = (c_OS_DIV > 1) ? $clog2(c_OS_DIV) : 1;
  localparam int c_BIT_W   = $clog2(DATA_WIDTH);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(c_OS_DIV - 1);
  localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(DATA_WIDTH - 1);
  localparam bit c_HAS_PAR = (PARITY != "NONE");
  localparam bit c_ODD     = (PARITY == "ODD");

  localparam logic [2:0] c_S_IDLE   = 3'd0;
  localparam logic [2:0] c_S_START  = 3'd1;
  localparam logic [2:0] c_S_DATA   = 3'd2;
  localparam logic [2:0] c_S_PARITY = 3'd3;
  localparam logic [2:0] c_S_STOP   = 3'd4;

  logic [2:0]            r_state;
  logic [2:0]            w_next;
  logic                  r_rx_meta;
  logic                  r_rxs;
  logic                  r_rxs_d;
  logic [c_DIV_W-1:0]    r_div;
  logic [3:0]            r_tick_cnt;
  logic                  r_s7;
  logic                  r_s8;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [c_BIT_W-1:0]    r_bit_cnt;
  logic                  r_perr;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_done;
  logic                  r_rx_error;

  logic                  w_fall;
  logic                  w_start;
  logic                  w_tick;
  logic [3:0]            w_idx;
  logic                  w_at9;
  logic                  w_at15;
  logic                  w_maj;
  logic                  w_busy;
  logic                  w_shift_en;
  logic                  w_bit_adv;
  logic                  w_par_chk;
  logic                  w_finish;

  // Tick k of a bit lands k oversample periods after start detection, so the
  // label of the tick currently firing is one ahead of the stored count.
  assign w_fall  = r_rxs_d & ~r_rxs;
  assign w_start = (r_state == c_S_IDLE) & w_fall;
  assign w_tick  = (r_div == c_DIV_LAST);
  assign w_idx   = r_tick_cnt + 4'd1;
  assign w_at9   = w_tick & (w_idx == 4'd9);
  assign w_at15  = w_tick & (w_idx == 4'd15);
  assign w_maj   = (r_s7 & r_s8) | (r_s7 & r_rxs) | (r_s8 & r_rxs);

  // Two-flop synchronizer plus a delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
      r_rxs_d   <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rxs     <= r_rx_meta;
      r_rxs_d   <= r_rxs;
    end
  end

  // Oversample divider and tick counter, realigned to every detected start
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_div      <= '0;
      r_tick_cnt <= '0;
    end else if (w_start) begin
      r_div      <= '0;
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_div      <= '0;
      r_tick_cnt <= w_idx;
    end else begin
      r_div      <= r_div + 1'b1;
    end
  end

  // Capture the first two votes; the third is the live sample on tick 9
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_s7 <= 1'b1;
      r_s8 <= 1'b1;
    end else if (w_tick) begin
      if (w_idx == 4'd7) r_s7 <= r_rxs;
      if (w_idx == 4'd8) r_s8 <= r_rxs;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) r_state <= c_S_IDLE;
    else        r_state <= w_next;
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_S_IDLE:   if (w_fall) w_next = c_S_START;
      c_S_START: begin
        if (w_at9 && w_maj) w_next = c_S_IDLE;
        else if (w_at15)    w_next = c_S_DATA;
      end
      c_S_DATA:   if (w_at15 && (r_bit_cnt == c_BIT_LAST))
                    w_next = c_HAS_PAR ? c_S_PARITY : c_S_STOP;
      c_S_PARITY: if (w_at15) w_next = c_S_STOP;
      c_S_STOP:   if (w_at9) w_next = c_S_IDLE;
      default:    w_next = c_S_IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    w_busy     = (r_state != c_S_IDLE);
    w_shift_en = (r_state == c_S_DATA) & w_at9;
    w_bit_adv  = (r_state == c_S_DATA) & w_at15;
    w_par_chk  = (r_state == c_S_PARITY) & w_at9;
    w_finish   = (r_state == c_S_STOP) & w_at9;
  end

  // Data shift register, bit counter and parity check
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_perr    <= 1'b0;
    end else if (w_start) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_perr    <= 1'b0;
    end else begin
      if (w_shift_en) r_shift   <= {w_maj, r_shift[DATA_WIDTH-1:1]};
      if (w_bit_adv)  r_bit_cnt <= r_bit_cnt + 1'b1;
      if (w_par_chk)  r_perr    <= (^r_shift) ^ w_maj ^ c_ODD;
    end
  end

  // Output register: word, error flag and strobe all update on one edge
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_rx_data  <= '0;
      r_rx_done  <= 1'b0;
      r_rx_error <= 1'b0;
    end else begin
      r_rx_done <= w_finish;
      if (w_finish) begin
        r_rx_data  <= r_shift;
        r_rx_error <= r_perr | ~w_maj;
      end
    end
  end

  assign rx_data  = r_rx_data;
  assign rx_done  = r_rx_done;
  assign rx_error = r_rx_error;
  assign rx_busy  = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os16.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_os16
// Purpose  : Scoreboard bench for uart_rx_os16 at the default parameters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_os16;

  localparam int c_BIT_NS  = 8640;   // 16 * 27 clocks of 20 ns
  localparam int c_FAST_NS = 8471;   // sender baud +2%
  localparam int c_SLOW_NS = 8816;   // sender baud -2%
  localparam int c_LAT     = 10 * 16 * 27 + 9 * 27 + 3;

  logic       clk   = 1'b0;
  logic       arstn = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_error;
  logic       rx_busy;

  int         n_total  = 0;
  int         n_bad    = 0;
  int         n_pushed = 0;
  int         done_cnt = 0;
  logic [8:0] q_exp[$];
  logic [8:0] m_exp;
  longint     t_fall = 0;
  longint     t_done = 0;
  int         lat;

  always #10 clk = ~clk;

  uart_rx_os16 #(
    .CLK_FREQ  (50_000_000),
    .BAUD_RATE (115200),
    .PARITY    ("EVEN"),
    .DATA_WIDTH(8)
  ) u_dut (
    .clk     (clk),
    .arstn   (arstn),
    .rx      (rx),
    .rx_data (rx_data),
    .rx_done (rx_done),
    .rx_error(rx_error),
    .rx_busy (rx_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one 8E1-style frame; the parity bit may be inverted and the stop bit forced
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop_bit,
                            input int bit_ns, input bit expect_it);
    logic pbit;
    pbit = (^d) ^ bad_par;
    if (expect_it) begin
      q_exp.push_back({bad_par | ~stop_bit, d});
      n_pushed++;
    end
    rx = 1'b0;
    t_fall = $time;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #(bit_ns);
    end
    rx = pbit;
    #(bit_ns);
    rx = stop_bit;
    #(bit_ns);
  endtask

  // Scoreboard consumer: every strobe must match the oldest queued frame
  always @(negedge clk) begin
    if (rx_done === 1'b1) begin
      done_cnt++;
      t_done = $time;
      chk("done_expected", {31'd0, q_exp.size() != 0}, 32'd1);
      if (q_exp.size() != 0) begin
        m_exp = q_exp.pop_front();
        chk("rx_data", {24'd0, rx_data}, {24'd0, m_exp[7:0]});
        chk("rx_error", {31'd0, rx_error}, {31'd0, m_exp[8]});
      end
    end
  end

  initial begin
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_data", {24'd0, rx_data}, 32'd0);
    chk("rst_done", {31'd0, rx_done}, 32'd0);
    chk("rst_error", {31'd0, rx_error}, 32'd0);
    chk("rst_busy", {31'd0, rx_busy}, 32'd0);
    arstn = 1'b1;
    repeat (20) @(posedge clk);
    #7;

    // Clean frame and its latency from the rx falling edge
    send_frame(8'hC9, 1'b0, 1'b1, c_BIT_NS, 1'b1);
    lat = int'((t_done - 10 - t_fall + 19) / 20);
    chk("latency", (lat >= c_LAT - 1 && lat <= c_LAT + 1) ? c_LAT : lat, c_LAT);
    #(c_BIT_NS);

    // Parity error, then a clean frame clears the flag
    send_frame(8'hC9, 1'b1, 1'b1, c_BIT_NS, 1'b1);
    send_frame(8'h3A, 1'b0, 1'b1, c_BIT_NS, 1'b1);
    #(c_BIT_NS);

    // Framing error followed by a break: one report only
    send_frame(8'h55, 1'b0, 1'b0, c_BIT_NS, 1'b1);
    #(5 * c_BIT_NS);
    rx = 1'b1;
    #(c_BIT_NS);
    send_frame(8'hA5, 1'b0, 1'b1, c_BIT_NS, 1'b1);
    #(c_BIT_NS);

    // Short and longer low glitches are rejected as false starts
    rx = 1'b0;
    #100;
    rx = 1'b1;
    #(c_BIT_NS - 100);
    chk("glitch100_busy", {31'd0, rx_busy}, 32'd0);
    rx = 1'b0;
    #3000;
    rx = 1'b1;
    #(c_BIT_NS - 3000);
    chk("glitch3us_busy", {31'd0, rx_busy}, 32'd0);
    send_frame(8'h81, 1'b0, 1'b1, c_BIT_NS, 1'b1);
    #(c_BIT_NS);

    // Back-to-back frames with baud mismatch in both directions
    send_frame(8'h00, 1'b0, 1'b1, c_FAST_NS, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1, c_FAST_NS, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b1, c_FAST_NS, 1'b1);
    #(c_BIT_NS);
    send_frame(8'h00, 1'b0, 1'b1, c_SLOW_NS, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1, c_SLOW_NS, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b1, c_SLOW_NS, 1'b1);
    #(c_BIT_NS);

    // Reset from mid-data until the stop bit drops the frame
    fork
      send_frame(8'h77, 1'b0, 1'b1, c_BIT_NS, 1'b0);
      begin
        #(6 * c_BIT_NS + c_BIT_NS / 2);
        arstn = 1'b0;
        @(negedge clk);
        chk("abort_data", {24'd0, rx_data}, 32'd0);
        chk("abort_done", {31'd0, rx_done}, 32'd0);
        chk("abort_error", {31'd0, rx_error}, 32'd0);
        chk("abort_busy", {31'd0, rx_busy}, 32'd0);
        #(4 * c_BIT_NS - 100);
        arstn = 1'b1;
      end
    join
    #(c_BIT_NS);
    chk("post_rst_busy", {31'd0, rx_busy}, 32'd0);
    send_frame(8'h77, 1'b0, 1'b1, c_BIT_NS, 1'b1);
    #(c_BIT_NS);

    chk("queue_empty", q_exp.size(), 32'd0);
    chk("done_count", done_cnt, n_pushed);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
